// File: rtl/prf_wb_pkg.sv
// Shared configuration and types for the PRF write-back arbiter.
// Contents:
//   N_SRC, N_WP, TAG_W, DATA_W, CNT_W  - block geometry
//   SRC_IDX_W                          - width of a source index / rr pointer
//   src_e                              - completing-unit index (ADD..CSR)
//   wp_s                               - one registered write port {en, tag, data}
//   popcount()                         - occupancy count helper
package prf_wb_pkg;

  localparam int N_SRC     = 7;
  localparam int N_WP      = 2;
  localparam int TAG_W     = 8;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;
  localparam int SRC_IDX_W = $clog2(N_SRC);

  typedef enum logic [SRC_IDX_W-1:0] {
    SRC_ADD  = 3'd0,
    SRC_LOAD = 3'd1,
    SRC_MUL  = 3'd2,
    SRC_DIV  = 3'd3,
    SRC_BR   = 3'd4,
    SRC_PASS = 3'd5,
    SRC_CSR  = 3'd6
  } src_e;

  typedef struct packed {
    logic              en;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wp_s;

  // Number of set bits in a per-source vector.
  function automatic int popcount(input logic [N_SRC-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N_SRC; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prf_wb_arbiter_rr_pick_n.sv
// Circular priority picker: walks the request vector starting at i_start,
// wrapping at N, and hands out up to NG one-hot grants in scan order.
// Ports:
//   i_req   - request vector
//   i_start - first index examined
//   o_gnt   - o_gnt[g] is the one-hot grant for output slot g (0 = first found)
//   o_last  - index of the last granted request (valid when o_any)
//   o_any   - at least one grant issued
module rr_pick_n
  import prf_wb_pkg::*;
#(
  parameter int N     = N_SRC,
  parameter int NG    = N_WP,
  parameter int PTR_W = SRC_IDX_W
) (
  input  logic [N-1:0]          i_req,
  input  logic [PTR_W-1:0]      i_start,
  output logic [NG-1:0][N-1:0]  o_gnt,
  output logic [PTR_W-1:0]      o_last,
  output logic                  o_any
);

  // Scan positions start, start+1, ... (mod N); each hit fills the next grant slot.
  always_comb begin
    int         v_cnt;
    logic [PTR_W:0] v_sum;
    logic [PTR_W:0] v_pos;
    o_gnt  = '0;
    o_last = '0;
    v_cnt  = 0;
    v_sum  = '0;
    v_pos  = '0;
    for (int k = 0; k < N; k++) begin
      v_sum = {1'b0, i_start} + (PTR_W+1)'(k);
      if (v_sum >= (PTR_W+1)'(N)) begin
        v_pos = v_sum - (PTR_W+1)'(N);
      end else begin
        v_pos = v_sum;
      end
      for (int i = 0; i < N; i++) begin
        if ((v_pos == (PTR_W+1)'(i)) && i_req[i] && (v_cnt < NG)) begin
          for (int g = 0; g < NG; g++) begin
            if (v_cnt == g) begin
              o_gnt[g][i] = 1'b1;
            end else begin
              o_gnt[g][i] = o_gnt[g][i];
            end
          end
          o_last = PTR_W'(i);
          v_cnt  = v_cnt + 1;
        end else begin
          v_cnt = v_cnt;
        end
      end
    end
    o_any = (v_cnt != 0);
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// PRF write-back arbiter. Each completing unit owns a one-entry holding slot;
// a round-robin picker drains up to N_WP occupied slots per cycle onto the
// registered PRF write ports, which double as the wake-up broadcast.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   i_flush         - discard all pending results (exception / mret)
//   i_src_valid     - per-source result valid
//   o_src_ready     - per-source slot can accept (refill allowed when granted)
//   i_src_tag/data  - per-source phy tag / data, source i at [i*W +: W]
//   o_wp_en/tag/data- registered PRF write ports, port p at [p*W +: W]
//   o_pending       - slot occupancy
//   o_conflict_cnt  - saturating count of cycles with more than N_WP slots occupied
module prf_wb_arbiter
  import prf_wb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic [N_SRC-1:0]         i_src_valid,
  output logic [N_SRC-1:0]         o_src_ready,
  input  logic [N_SRC*TAG_W-1:0]   i_src_tag,
  input  logic [N_SRC*DATA_W-1:0]  i_src_data,
  output logic [N_WP-1:0]          o_wp_en,
  output logic [N_WP*TAG_W-1:0]    o_wp_tag,
  output logic [N_WP*DATA_W-1:0]   o_wp_data,
  output logic [N_SRC-1:0]         o_pending,
  output logic [CNT_W-1:0]         o_conflict_cnt
);

  logic [N_SRC-1:0]            r_occ;
  logic [TAG_W-1:0]            r_tag  [N_SRC];
  logic [DATA_W-1:0]           r_data [N_SRC];
  logic [SRC_IDX_W-1:0]        r_rr_ptr;
  wp_s                         r_wp   [N_WP];
  logic [CNT_W-1:0]            r_conflict_cnt;

  logic [N_WP-1:0][N_SRC-1:0]  w_gnt;
  logic [N_SRC-1:0]            w_gnt_any;
  logic [SRC_IDX_W-1:0]        w_last;
  logic                        w_any;
  logic [N_SRC-1:0]            w_ready;
  logic [N_SRC-1:0]            w_store;
  logic [TAG_W-1:0]            w_tag_in  [N_SRC];
  logic [DATA_W-1:0]           w_data_in [N_SRC];
  wp_s                         w_wp_nxt  [N_WP];

  rr_pick_n #(
    .N     (N_SRC),
    .NG    (N_WP),
    .PTR_W (SRC_IDX_W)
  ) u_pick (
    .i_req   (r_occ),
    .i_start (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_last  (w_last),
    .o_any   (w_any)
  );

  // Unpack inputs and form the handshake. A granted slot may refill in the
  // same cycle. Tag 0 completes the handshake but is never stored.
  always_comb begin
    w_gnt_any = '0;
    for (int p = 0; p < N_WP; p++) begin
      w_gnt_any = w_gnt_any | w_gnt[p];
    end
    for (int i = 0; i < N_SRC; i++) begin
      w_tag_in[i]  = i_src_tag[i*TAG_W +: TAG_W];
      w_data_in[i] = i_src_data[i*DATA_W +: DATA_W];
      w_ready[i]   = !i_flush && (!r_occ[i] || w_gnt_any[i]);
      w_store[i]   = i_src_valid[i] && w_ready[i] && (w_tag_in[i] != {TAG_W{1'b0}});
    end
  end

  // Mux the granted slots onto the next write-port values (one-hot AND-OR).
  always_comb begin
    for (int p = 0; p < N_WP; p++) begin
      w_wp_nxt[p] = '0;
      for (int i = 0; i < N_SRC; i++) begin
        w_wp_nxt[p].en   = w_wp_nxt[p].en | w_gnt[p][i];
        w_wp_nxt[p].tag  = w_wp_nxt[p].tag  | ({TAG_W{w_gnt[p][i]}}  & r_tag[i]);
        w_wp_nxt[p].data = w_wp_nxt[p].data | ({DATA_W{w_gnt[p][i]}} & r_data[i]);
      end
    end
  end

  // Holding slots: capture on store, release on grant, all cleared by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_flush) begin
      r_occ <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_store[i]) begin
          r_occ[i]  <= 1'b1;
          r_tag[i]  <= w_tag_in[i];
          r_data[i] <= w_data_in[i];
        end else if (w_gnt_any[i]) begin
          r_occ[i]  <= 1'b0;
        end else begin
          r_occ[i]  <= r_occ[i];
        end
      end
    end
  end

  // Round-robin pointer resumes just after the last source served.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_last == SRC_IDX_W'(N_SRC-1)) ? {SRC_IDX_W{1'b0}}
                                                  : (w_last + SRC_IDX_W'(1));
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Registered write ports; a flush kills the writes granted in its cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_WP; p++) begin
      if (reset || i_flush) begin
        r_wp[p] <= '0;
      end else begin
        r_wp[p] <= w_wp_nxt[p];
      end
    end
  end

  // Conflict counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if ((popcount(r_occ) > N_WP) && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  // Output flattening.
  always_comb begin
    for (int p = 0; p < N_WP; p++) begin
      o_wp_en[p]                       = r_wp[p].en;
      o_wp_tag[p*TAG_W +: TAG_W]       = r_wp[p].tag;
      o_wp_data[p*DATA_W +: DATA_W]    = r_wp[p].data;
    end
    o_src_ready    = w_ready;
    o_pending      = r_occ;
    o_conflict_cnt = r_conflict_cnt;
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Self-checking bench for prf_wb_arbiter: directed vector table, a hand-written
// no-starvation sequence, and randomized traffic against a queue-based model.
module tb_prf_wb_arbiter;
  import prf_wb_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0]         src_ready;
  logic [N_SRC*TAG_W-1:0]   src_tag;
  logic [N_SRC*DATA_W-1:0]  src_data;
  logic [N_WP-1:0]          wp_en;
  logic [N_WP*TAG_W-1:0]    wp_tag;
  logic [N_WP*DATA_W-1:0]   wp_data;
  logic [N_SRC-1:0]         pending;
  logic [CNT_W-1:0]         conflict_cnt;

  int checks   = 0;
  int failures = 0;
  logic [N_SRC-1:0] last_ready;

  always #5 clk = ~clk;

  prf_wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_flush        (flush),
    .i_src_valid    (src_valid),
    .o_src_ready    (src_ready),
    .i_src_tag      (src_tag),
    .i_src_data     (src_data),
    .o_wp_en        (wp_en),
    .o_wp_tag       (wp_tag),
    .o_wp_data      (wp_data),
    .o_pending      (pending),
    .o_conflict_cnt (conflict_cnt)
  );

  // ---------------- reference model ----------------
  bit               m_occ  [N_SRC];
  logic [TAG_W-1:0] m_tag  [N_SRC];
  logic [DATA_W-1:0] m_data[N_SRC];
  int               m_rr;
  int               m_cnt;
  logic [N_WP-1:0]  m_en;
  logic [TAG_W-1:0] m_wtag [N_WP];
  logic [DATA_W-1:0] m_wdata[N_WP];
  logic [N_SRC-1:0] m_ready;
  int               m_pick[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sources served this cycle, in port order, walking from the rr pointer.
  function automatic void model_pick();
    bit granted[N_SRC];
    m_pick.delete();
    for (int j = 0; j < N_SRC; j++) begin
      int idx = (m_rr + j) % N_SRC;
      if (m_occ[idx] && m_pick.size() < N_WP) m_pick.push_back(idx);
    end
    foreach (granted[i]) granted[i] = 0;
    foreach (m_pick[k]) granted[m_pick[k]] = 1;
    for (int i = 0; i < N_SRC; i++) m_ready[i] = !flush && (!m_occ[i] || granted[i]);
  endfunction

  function automatic void model_edge();
    int pop = 0;
    if (reset) begin
      foreach (m_occ[i]) begin m_occ[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
      m_rr = 0; m_cnt = 0; m_en = '0;
      foreach (m_wtag[p]) begin m_wtag[p] = '0; m_wdata[p] = '0; end
      return;
    end
    foreach (m_occ[i]) pop += int'(m_occ[i]);
    if (pop > N_WP && m_cnt < 65535) m_cnt++;
    m_en = '0;
    if (flush) begin
      foreach (m_occ[i]) m_occ[i] = 0;
      m_rr = 0;
      return;
    end
    foreach (m_pick[k]) begin
      m_en[k]    = 1'b1;
      m_wtag[k]  = m_tag[m_pick[k]];
      m_wdata[k] = m_data[m_pick[k]];
      m_occ[m_pick[k]] = 0;
    end
    for (int i = 0; i < N_SRC; i++) begin
      logic [TAG_W-1:0] t = src_tag[i*TAG_W +: TAG_W];
      if (src_valid[i] && !m_occ[i] && t != '0) begin
        m_occ[i]  = 1;
        m_tag[i]  = t;
        m_data[i] = src_data[i*DATA_W +: DATA_W];
      end
    end
    if (m_pick.size() > 0) m_rr = (m_pick[m_pick.size()-1] + 1) % N_SRC;
  endfunction

  // One clock: check ready mid-cycle, advance model at the edge, check outputs.
  task automatic step();
    logic [N_SRC-1:0] exp_pend;
    model_pick();
    @(negedge clk);
    last_ready = src_ready;
    if (!reset) chk("src_ready", src_ready, m_ready);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N_SRC; i++)
      for (int j = i + 1; j < N_SRC; j++)
        assert (!(m_occ[i] && m_occ[j] && m_tag[i] == m_tag[j]))
          else $error("duplicate tag %0h in slots %0d and %0d", m_tag[i], i, j);
    foreach (m_occ[i]) exp_pend[i] = m_occ[i];
    chk("wp_en", wp_en, m_en);
    for (int p = 0; p < N_WP; p++) begin
      if (m_en[p]) begin
        chk($sformatf("wp_tag%0d", p), wp_tag[p*TAG_W +: TAG_W], m_wtag[p]);
        chk($sformatf("wp_data%0d", p), wp_data[p*DATA_W +: DATA_W], m_wdata[p]);
      end
    end
    if (wp_en == 2'b11) chk("wp_tag_distinct", wp_tag[7:0] != wp_tag[15:8], 1'b1);
    chk("pending", pending, exp_pend);
    chk("conflict_cnt", conflict_cnt, 16'(m_cnt));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               rst;
    bit               fl;
    logic [6:0]       valid;
    logic [7:0]       tbase;
    logic [31:0]      dbase;
    bit               chk_rdy;
    logic [6:0]       rdy;
    logic [1:0]       en;
    logic [7:0]       t0;
    logic [7:0]       t1;
    logic [31:0]      d0;
    logic [6:0]       pend;
    logic [15:0]      cnt;
  } vec_t;

  vec_t tv[$];

  function automatic void add(bit rst, bit fl, logic [6:0] valid, logic [7:0] tbase,
                              logic [31:0] dbase, bit chk_rdy, logic [6:0] rdy,
                              logic [1:0] en, logic [7:0] t0, logic [7:0] t1,
                              logic [31:0] d0, logic [6:0] pend, logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.valid = valid; v.tbase = tbase; v.dbase = dbase;
    v.chk_rdy = chk_rdy; v.rdy = rdy; v.en = en; v.t0 = t0; v.t1 = t1; v.d0 = d0;
    v.pend = pend; v.cnt = cnt;
    tv.push_back(v);
  endfunction

  initial begin
    bit mul_seen;
    int mul_cycle;
    int tag_ctr;
    reset = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
    foreach (m_occ[i]) begin m_occ[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
    m_rr = 0; m_cnt = 0; m_en = '0;

    //   rst fl  valid  tbase  dbase          chk rdy    en    t0     t1     d0             pend   cnt
    // single ADD result, latency 2
    add(1, 0, 7'h00, 8'h00, 32'h0,          0, 7'h00, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    add(0, 0, 7'h01, 8'h25, 32'hDEADBEEF,   1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h01, 16'd0);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b01, 8'h25, 8'h00, 32'hDEADBEEF,   7'h00, 16'd0);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    // all seven at once: occupancy 7,5,3 exceeds two ports
    add(1, 0, 7'h00, 8'h00, 32'h0,          0, 7'h00, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    add(0, 0, 7'h7F, 8'h21, 32'hC0DE0021,   1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h7F, 16'd0);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h03, 2'b11, 8'h21, 8'h22, 32'hC0DE0021,   7'h7C, 16'd1);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h0F, 2'b11, 8'h23, 8'h24, 32'hC0DE0023,   7'h70, 16'd2);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h3F, 2'b11, 8'h25, 8'h26, 32'hC0DE0025,   7'h40, 16'd3);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b01, 8'h27, 8'h00, 32'hC0DE0027,   7'h00, 16'd3);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd3);
    // BR with tag 0 (tbase FC + 4 wraps to 0)
    add(1, 0, 7'h00, 8'h00, 32'h0,          0, 7'h00, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    add(0, 0, 7'h10, 8'hFC, 32'h12345678,   1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    // five occupied, then flush with new inputs presented
    add(0, 0, 7'h1F, 8'h31, 32'hAAAA0000,   1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h1F, 16'd0);
    add(0, 1, 7'h1F, 8'h41, 32'hBBBB0000,   1, 7'h00, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd1);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd1);
    // reset together with flush while slots are pending
    add(0, 0, 7'h07, 8'h51, 32'hCCCC0000,   1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h07, 16'd1);
    add(1, 1, 7'h00, 8'h00, 32'h0,          0, 7'h00, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);
    add(0, 0, 7'h00, 8'h00, 32'h0,          1, 7'h7F, 2'b00, 8'h00, 8'h00, 32'h0,          7'h00, 16'd0);

    foreach (tv[n]) begin
      reset = tv[n].rst; flush = tv[n].fl; src_valid = tv[n].valid;
      for (int i = 0; i < N_SRC; i++) begin
        src_tag[i*TAG_W +: TAG_W]    = tv[n].tbase + TAG_W'(i);
        src_data[i*DATA_W +: DATA_W] = tv[n].dbase + DATA_W'(i);
      end
      step();
      if (tv[n].chk_rdy) chk($sformatf("vec%0d_ready", n), last_ready, tv[n].rdy);
      chk($sformatf("vec%0d_wp_en", n), wp_en, tv[n].en);
      if (tv[n].en[0]) begin
        chk($sformatf("vec%0d_tag0", n), wp_tag[7:0], tv[n].t0);
        chk($sformatf("vec%0d_data0", n), wp_data[31:0], tv[n].d0);
      end
      if (tv[n].en[1]) chk($sformatf("vec%0d_tag1", n), wp_tag[15:8], tv[n].t1);
      chk($sformatf("vec%0d_pending", n), pending, tv[n].pend);
      chk($sformatf("vec%0d_cnt", n), conflict_cnt, tv[n].cnt);
    end

    // LOAD streams back-to-back while MUL waits: LOAD never stalls, MUL is served.
    reset = 1'b0; flush = 1'b0;
    src_valid = 7'h06;
    src_tag = '0;
    src_tag[1*TAG_W +: TAG_W] = 8'h70;
    src_tag[2*TAG_W +: TAG_W] = 8'h60;
    step();
    mul_seen = 0; mul_cycle = 0;
    for (int k = 1; k <= 6; k++) begin
      src_valid = 7'h02;
      src_tag[1*TAG_W +: TAG_W] = 8'h70 + 8'(k);
      step();
      chk($sformatf("load_ready_%0d", k), last_ready[1], 1'b1);
      for (int p = 0; p < N_WP; p++)
        if (wp_en[p] && wp_tag[p*TAG_W +: TAG_W] == 8'h60 && !mul_seen) begin
          mul_seen = 1; mul_cycle = k;
        end
    end
    chk("mul_no_starve", (mul_seen && mul_cycle <= 4), 1'b1);
    src_valid = '0;
    step(); step();

    // Randomized traffic with occasional flush/reset; tags unique by rolling counter.
    tag_ctr = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 127) == 0);
      flush = ($urandom_range(0, 31) == 0);
      src_valid = N_SRC'($urandom);
      for (int i = 0; i < N_SRC; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          src_tag[i*TAG_W +: TAG_W] = '0;
        end else begin
          src_tag[i*TAG_W +: TAG_W] = TAG_W'(tag_ctr);
          tag_ctr = (tag_ctr == 255) ? 1 : tag_ctr + 1;
        end
        src_data[i*DATA_W +: DATA_W] = $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
